chacha_arbiter: RTL and testbench
=================================

Name: chacha_arbiter

Overview:
- Shares one chacha_top instance between NUM_REQ requesters, e.g. transmitter manager (index 0) and receiver manager (index 1) in a combined link endpoint.
- Arbitrates round-robin, latches the winner's operands, sequences the core's start/ready/valid handshake, and returns the 512-bit result to the granted requester only.
- Sits between the managers and chacha_top; it is the only driver of the core's inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- KEY_WIDTH, 256, ChaCha key width
- NONCE_WIDTH, 96, nonce width
- BLOCK_COUNT_WIDTH, 32, block counter width
- DATA_WIDTH, 512, message/keystream block width
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_key  in  NUM_REQ*KEY_WIDTH  flattened; slice i = requester i
- req_nonce  in  NUM_REQ*NONCE_WIDTH  flattened
- req_block_count  in  NUM_REQ*BLOCK_COUNT_WIDTH  flattened
- req_data  in  NUM_REQ*DATA_WIDTH  flattened
- req_ack  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_ready  in  NUM_REQ  requester accepts result
- rsp_data  out  DATA_WIDTH  result, shared bus
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- core_key  out  KEY_WIDTH  to chacha key
- core_nonce  out  NONCE_WIDTH  to chacha nonce
- core_block_count  out  BLOCK_COUNT_WIDTH  to chacha block_count
- core_data  out  DATA_WIDTH  to chacha data_in
- core_start  out  1  one-cycle start pulse
- core_ready  in  1  chacha idle
- core_valid  in  1  chacha result pulse
- core_data_out  in  DATA_WIDTH  chacha data_out

Behaviour:
- Reset (async, active-high):
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: req_ack, rsp_valid, rsp_err, core_start, and all core_* operand registers.
  - A core operation in flight is abandoned; a later core_valid is ignored because it does not arrive in BUSY.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Winner = first set req_valid bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ack[winner] = 1, combinational, only in IDLE.
  - At the clock edge: the winner's operands are registered into core_*, its index goes to grant, and state -> ISSUE.
  - Requesters hold operands stable while req_valid is high and drop req_valid after seeing ack.
- ISSUE:
  - core_start = 1 for exactly one cycle, in the first cycle in which core_ready = 1; state -> BUSY.
  - If core_ready = 0, stay in ISSUE with core_start = 0.
- BUSY:
  - On core_valid, capture core_data_out into rsp_data and set rsp_err = 0; state -> RESP.
  - core_valid in any other state is ignored.
- RESP:
  - rsp_valid[grant] = 1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant]: rsp_valid -> 0, rr_ptr = (grant + 1) mod NUM_REQ, state -> IDLE.
  - rsp_ready on other indices is ignored.
- Latency:
  - From req_ack to core_start is 1 cycle when core_ready = 1.
  - From core_valid to rsp_valid is 1 cycle.
  - Minimum gap between grants is 1 IDLE cycle.
- Operand registers hold their values until the next grant. Only one request is outstanding; no queuing.
- Simultaneous requests: exactly one ack per IDLE cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0, 1, ..., NUM_REQ-1, 0, ...
- A requester that deasserts req_valid before being acked is simply not granted.

Optional Feature:
- Macro: CHACHA_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no core_valid: state -> RESP, rsp_data = 0, rsp_err = 1.
  - core_valid in the same cycle as the timeout wins, and rsp_err = 0.
- Undefined: BUSY waits indefinitely, rsp_err is tied to 0, and no counter logic is built.

Decomposition:
- Package chacha_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, BUSY, RESP}
  - localparam GRANT_W = $clog2(NUM_REQ)
  - timeout counter width
  - default width constants matching chacha_top
- Sub-module rr_arbiter, parameterised NUM_REQ:
  - Purely combinational masked priority pick.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded index.
  - The FSM, operand registers and result register stay in chacha_arbiter.

Test Plan:
- Single request: req_valid = 01, key = 0x00..1F, nonce = 0x000000090000004A00000000, block_count = 1, data = 0 → ack[0] in cycle 0, core_start in cycle 1, and after core_valid rsp_valid = 01 with rsp_data equal to the RFC 8439 section 2.3.2 keystream.
- Contention: req_valid = 11 held for 4 transactions from reset → grant order 0, 1, 0, 1; exactly one ack per IDLE cycle.
- Backpressure:
  - core_ready = 0 for 5 cycles → core_start stays 0 and is asserted exactly once after core_ready rises.
  - rsp_ready[grant] = 0 for 3 cycles → rsp_valid and rsp_data stable, and no new ack is issued.
- Stray handshakes: core_valid pulsed in IDLE, and rsp_ready[1] asserted while grant = 0 → no state change, no rsp_valid.
- Reset mid-BUSY: assert reset, then a late core_valid arrives → all outputs 0, no rsp_valid, and the next request is granted to index 0.
- With CHACHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, core_valid never arrives → rsp_valid after 8 BUSY cycles with rsp_err = 1 and rsp_data = 0.

Source files
------------

// File: rtl/chacha_arb_pkg.sv
// chacha_arb_pkg: FSM state type and default widths for chacha_arbiter.
// Shared by chacha_arbiter and rr_arbiter.
package chacha_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_KEY_W       = 256;
    localparam int DEF_NONCE_W     = 96;
    localparam int DEF_BCNT_W      = 32;
    localparam int DEF_DATA_W      = 512;
    localparam int DEF_TIMEOUT     = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tmo_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int GRANT_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/chacha_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i.
// Returns a one-hot grant and its encoded index.
module rr_arbiter
    import chacha_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = GRANT_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [GW-1:0]      idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = GW'(j);
            end
        end
    end

endmodule

// File: rtl/chacha_arbiter.sv
// chacha_arbiter: shares one chacha_top between NUM_REQ requesters.
// Optional BUSY watchdog when CHACHA_ARB_TIMEOUT_EN is defined.
module chacha_arbiter
    import chacha_arb_pkg::*;
#(
    parameter int NUM_REQ           = DEF_NUM_REQ,
    parameter int KEY_WIDTH         = DEF_KEY_W,
    parameter int NONCE_WIDTH       = DEF_NONCE_W,
    parameter int BLOCK_COUNT_WIDTH = DEF_BCNT_W,
    parameter int DATA_WIDTH        = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]         req_key,
    input  logic [NUM_REQ*NONCE_WIDTH-1:0]       req_nonce,
    input  logic [NUM_REQ*BLOCK_COUNT_WIDTH-1:0] req_block_count,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    output logic [NUM_REQ-1:0]                   req_ack,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic                                 rsp_err,
    output logic [KEY_WIDTH-1:0]                 core_key,
    output logic [NONCE_WIDTH-1:0]               core_nonce,
    output logic [BLOCK_COUNT_WIDTH-1:0]         core_block_count,
    output logic [DATA_WIDTH-1:0]                core_data,
    output logic                                 core_start,
    input  logic                                 core_ready,
    input  logic                                 core_valid,
    input  logic [DATA_WIDTH-1:0]                core_data_out
);

    localparam int GW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("chacha_arbiter: unsupported parameter set");
    end

    arb_state_t                 state_q, state_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic [GW-1:0]              rr_q, rr_d;
    logic [GW-1:0]              win_idx;
    logic [NUM_REQ-1:0]         win_gnt;
    logic                       load;
    logic [KEY_WIDTH-1:0]       key_q;
    logic [NONCE_WIDTH-1:0]     nonce_q;
    logic [BLOCK_COUNT_WIDTH-1:0] bcnt_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

`ifdef CHACHA_ARB_TIMEOUT_EN
    localparam int CW = tmo_w(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign core_key         = key_q;
    assign core_nonce       = nonce_q;
    assign core_block_count = bcnt_q;
    assign core_data        = data_q;
    assign rsp_data         = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        rsp_data_d = rsp_data_q;
        load       = 1'b0;
        req_ack    = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
`ifdef CHACHA_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|win_gnt) begin
                    req_ack = win_gnt;
                    grant_d = win_idx;
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    core_start = 1'b1;
                    state_d    = BUSY;
`ifdef CHACHA_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            BUSY: begin
                if (core_valid) begin
                    rsp_data_d = core_data_out;
                    state_d    = RESP;
`ifdef CHACHA_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d = '0;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            bcnt_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            rsp_data_q <= rsp_data_d;
            if (load) begin
                key_q   <= req_key[int'(win_idx)*KEY_WIDTH +: KEY_WIDTH];
                nonce_q <= req_nonce[int'(win_idx)*NONCE_WIDTH +: NONCE_WIDTH];
                bcnt_q  <= req_block_count[int'(win_idx)*BLOCK_COUNT_WIDTH +: BLOCK_COUNT_WIDTH];
                data_q  <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef CHACHA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_chacha_arbiter.sv
// tb_chacha_arbiter: scoreboard bench for chacha_arbiter with a stand-in core.
// Build with CHACHA_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_chacha_arbiter;

    localparam int N   = 2;
    localparam int KW  = 256;
    localparam int NW  = 96;
    localparam int BW  = 32;
    localparam int DW  = 512;
    localparam int TMO = 8;

    localparam logic [KW-1:0] K0 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [NW-1:0] N0 = 96'h000000090000004a00000000;
    localparam logic [BW-1:0] B0 = 32'h1;
    localparam logic [DW-1:0] D0 = '0;
    localparam logic [DW-1:0] KS = {
        128'h10f1e7e4d13b5915500fdd1fa32071c4,
        128'hc7d1f4c733c068030422aa9ac3d46c4e,
        128'hd2826446079faa0914c2d705d98b02a2,
        128'hb5129cd1de164eb9cbd083e8a2503c4e};
    localparam logic [KW-1:0] K1 = {8{32'hdeadbeef}};
    localparam logic [NW-1:0] N1 = 96'h0102030405060708090a0b0c;
    localparam logic [BW-1:0] B1 = 32'h7;
    localparam logic [DW-1:0] D1 = {16{32'h0f0f0f0f}};
    localparam logic [DW-1:0] E1 = {16{32'hd1a2b1e0}};

    typedef struct packed {
        logic [KW-1:0] k;
        logic [NW-1:0] n;
        logic [BW-1:0] b;
        logic [DW-1:0] d;
    } op_t;

    typedef struct packed {
        logic [N-1:0]  sel;
        logic          err;
        logic [DW-1:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    req_valid, req_ack, rsp_valid, rsp_ready;
    logic [N*KW-1:0] req_key;
    logic [N*NW-1:0] req_nonce;
    logic [N*BW-1:0] req_block_count;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   rsp_data, core_data, core_data_out;
    logic [KW-1:0]   core_key;
    logic [NW-1:0]   core_nonce;
    logic [BW-1:0]   core_block_count;
    logic            rsp_err, core_start, core_ready, core_valid;
    logic            cv_m, cv_s, mute;
    int              core_lat;

    op_t  op_q[$];
    rsp_t rsp_q[$];
    int   vecs = 0;
    int   errs = 0;

    assign core_valid = cv_m | cv_s;

    always #5 clk = ~clk;

    chacha_arbiter #(
        .NUM_REQ           (N),
        .KEY_WIDTH         (KW),
        .NONCE_WIDTH       (NW),
        .BLOCK_COUNT_WIDTH (BW),
        .DATA_WIDTH        (DW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_key          (req_key),
        .req_nonce        (req_nonce),
        .req_block_count  (req_block_count),
        .req_data         (req_data),
        .req_ack          (req_ack),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .core_key         (core_key),
        .core_nonce       (core_nonce),
        .core_block_count (core_block_count),
        .core_data        (core_data),
        .core_start       (core_start),
        .core_ready       (core_ready),
        .core_valid       (core_valid),
        .core_data_out    (core_data_out)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic op_t op_for(input int i);
        return (i == 0) ? {K0, N0, B0, D0} : {K1, N1, B1, D1};
    endfunction

    function automatic rsp_t rsp_for(input int i);
        rsp_t r;
        r.sel = N'(1) << i;
        r.err = 1'b0;
        r.d   = (i == 0) ? KS : E1;
        return r;
    endfunction

    task automatic note_ack(input int i);
        op_q.push_back(op_for(i));
        rsp_q.push_back(rsp_for(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [N-1:0] a);
        a = '0;
        for (int c = 0; c < 64 && a == '0; c++) begin
            @(negedge clk);
            a = req_ack;
        end
        chk("ack_seen", DW'(|a), DW'(1));
    endtask

    task automatic wait_start();
        logic s;
        s = 1'b0;
        for (int c = 0; c < 32 && !s; c++) begin
            @(negedge clk);
            s = core_start;
        end
        chk("start_seen", DW'(s), DW'(1));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && (rsp_q.size() != 0 || rsp_valid != '0); c++)
            @(negedge clk);
        chk("drain", DW'(rsp_q.size()), DW'(0));
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_ack"}, DW'(req_ack), DW'(0));
        chk({nm, "_rspv"}, DW'(rsp_valid), DW'(0));
        chk({nm, "_err"}, DW'(rsp_err), DW'(0));
        chk({nm, "_start"}, DW'(core_start), DW'(0));
        chk({nm, "_key"}, DW'(core_key), DW'(0));
        chk({nm, "_nonce"}, DW'(core_nonce), DW'(0));
        chk({nm, "_bc"}, DW'(core_block_count), DW'(0));
        chk({nm, "_cdata"}, core_data, DW'(0));
        chk({nm, "_rdata"}, rsp_data, DW'(0));
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        op_q.delete();
        rsp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // stand-in core: answers each start after core_lat cycles
    initial begin
        op_t o;
        cv_m          = 1'b0;
        core_data_out = '0;
        forever begin
            @(posedge clk);
            if (core_start && !reset) begin
                o = {core_key, core_nonce, core_block_count, core_data};
                repeat (core_lat) @(posedge clk);
                #1;
                if (!mute) begin
                    if (o.k == K0 && o.n == N0 && o.b == B0)
                        core_data_out = KS;
                    else
                        core_data_out = o.d ^ {o.k, o.k};
                    cv_m = 1'b1;
                    @(posedge clk);
                    #1;
                    cv_m = 1'b0;
                end
            end
        end
    end

    // monitor: operands at each start, responses on rsp_valid rise
    initial begin
        logic [N-1:0] prev_v;
        op_t  eo;
        rsp_t er;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                if (op_q.size() == 0) begin
                    chk("op_unexpected", DW'(core_start), DW'(0));
                end else begin
                    eo = op_q.pop_front();
                    chk("op_key", DW'(core_key), DW'(eo.k));
                    chk("op_nonce", DW'(core_nonce), DW'(eo.n));
                    chk("op_bc", DW'(core_block_count), DW'(eo.b));
                    chk("op_data", core_data, eo.d);
                end
            end
            if (rsp_valid != '0 && prev_v == '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", DW'(rsp_valid), DW'(0));
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_sel", DW'(rsp_valid), DW'(er.sel));
                    chk("rsp_data", rsp_data, er.d);
                    chk("rsp_err", DW'(rsp_err), DW'(er.err));
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "tb_chacha_arbiter: watchdog");
    end

    initial begin
        logic [N-1:0] a;
        int           cnt;
        logic         any;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        core_ready = 1'b1;
        cv_s      = 1'b0;
        mute      = 1'b0;
        core_lat  = 3;
        req_key   = {K1, K0};
        req_nonce = {N1, N0};
        req_block_count = {B1, B0};
        req_data  = {D1, D0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outs("reset");
        tick();
        reset = 1'b0;

        // single request, RFC 8439 block
        tick();
        req_valid = 2'b01;
        @(negedge clk);
        chk("single_ack", DW'(req_ack), DW'(2'b01));
        note_ack(0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_start", DW'(core_start), DW'(1));
        wait_drain();

        // contention from reset: 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_ack(a);
            chk("cont_onehot", DW'($countones(a)), DW'(1));
            chk("cont_order", DW'(a), DW'(N'(1) << (t % 2)));
            note_ack(t % 2);
        end
        tick();
        req_valid = '0;
        wait_drain();

        // core_ready backpressure
        tick();
        core_ready = 1'b0;
        req_valid  = 2'b10;
        wait_ack(a);
        chk("bp_ack", DW'(a), DW'(2'b10));
        note_ack(1);
        tick();
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cnt += int'(core_start);
        end
        chk("bp_no_start", DW'(cnt), DW'(0));
        tick();
        core_ready = 1'b1;
        @(negedge clk);
        chk("bp_start", DW'(core_start), DW'(1));
        @(negedge clk);
        chk("bp_start_once", DW'(core_start), DW'(0));
        wait_drain();

        // rsp_ready backpressure, stray rsp_ready[1]
        tick();
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        wait_ack(a);
        chk("hold_ack", DW'(a), DW'(2'b01));
        note_ack(0);
        tick();
        req_valid = 2'b10;
        any = 1'b0;
        for (int c = 0; c < 64 && !any; c++) begin
            @(negedge clk);
            any = |rsp_valid;
        end
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", DW'(rsp_valid), DW'(2'b01));
            chk("hold_data", rsp_data, KS);
            chk("hold_noack", DW'(req_ack), DW'(0));
            if (i < 2) @(negedge clk);
        end
        tick();
        rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release", DW'(rsp_valid), DW'(0));
        chk("hold_next_ack", DW'(req_ack), DW'(2'b10));
        note_ack(1);
        tick();
        req_valid = '0;
        wait_drain();

        // stray core_valid in IDLE
        tick();
        cv_s = 1'b1;
        tick();
        cv_s = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cnt += int'(|rsp_valid) + int'(core_start);
        end
        chk("stray_cv", DW'(cnt), DW'(0));
        tick();
        req_valid = 2'b01;
        wait_ack(a);
        chk("stray_after_ack", DW'(a), DW'(2'b01));
        note_ack(0);
        tick();
        req_valid = '0;
        wait_drain();

        // reset in BUSY, late core_valid ignored, pointer back to 0
        core_lat = 12;
        tick();
        req_valid = 2'b10;
        wait_ack(a);
        chk("rst_busy_ack", DW'(a), DW'(2'b10));
        note_ack(1);
        tick();
        req_valid = '0;
        wait_start();
        repeat (2) @(negedge clk);
        tick();
        reset = 1'b1;
        rsp_q.delete();
        op_q.delete();
        @(negedge clk);
        chk_zero_outs("rst_busy");
        tick();
        reset = 1'b0;
        any = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            any = any | (|rsp_valid);
        end
        chk("late_cv_ignored", DW'(any), DW'(0));
        core_lat = 3;
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ptr_zero", DW'(req_ack), DW'(2'b01));
        note_ack(0);
        tick();
        req_valid = '0;
        wait_drain();

`ifdef CHACHA_ARB_TIMEOUT_EN
        // watchdog: no core_valid ever
        begin
            rsp_t tr;
            mute = 1'b1;
            tick();
            req_valid = 2'b10;
            wait_ack(a);
            chk("tmo_ack", DW'(a), DW'(2'b10));
            op_q.push_back(op_for(1));
            tr.sel = 2'b10;
            tr.err = 1'b1;
            tr.d   = '0;
            rsp_q.push_back(tr);
            tick();
            req_valid = '0;
            wait_start();
            cnt = 0;
            any = 1'b0;
            for (int c = 0; c < 40 && !any; c++) begin
                @(negedge clk);
                cnt++;
                any = |rsp_valid;
            end
            chk("tmo_cycles", DW'(cnt), DW'(TMO + 1));
            wait_drain();
            mute = 1'b0;
        end
`endif

        chk("queues_empty", DW'(op_q.size() + rsp_q.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
